// File: rtl/pci_master_ctrl.sv
// pci_master_ctrl: initiator-side sequencer for the PCI core's user master ports.
// Turns one burst command into REQUEST/COMPLETE/M_READY/M_CBE sequencing,
// streams write/read data, and re-requests disconnected transfers.
// Optional feature: define PCI_MST_READ_MULTIPLE_EN to issue Memory Read
// Multiple for multi-word reads.
module pci_master_ctrl #(
  parameter int MAX_BURST   = 16,
  parameter int RETRY_LIMIT = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done_valid,
  output logic [1:0]  done_status,
  output logic        REQUEST,
  output logic        REQUESTHOLD,
  output logic        COMPLETE,
  output logic        M_WRDN,
  output logic        M_READY,
  output logic [3:0]  M_CBE,
  output logic [31:0] m_adio,
  input  logic        M_DATA_VLD,
  input  logic        M_SRC_EN,
  input  logic        M_DATA,
  input  logic        M_ADDR_N,
  input  logic        TIME_OUT,
  input  logic        STOPQ_N,
  input  logic        DEVSELQ_N,
  input  logic        I_IDLE,
  input  logic [31:0] ADIO_OUT,
  input  logic [39:0] CSR
);

  localparam int RW = $clog2(RETRY_LIMIT + 1) + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_ADDR, ST_DATA, ST_WAIT_END, ST_GAP, ST_DONE
  } state_t;

  state_t          r_state, w_next;
  logic [29:0]     r_addr;
  logic            r_write;
  logic [4:0]      r_rem;
  logic [RW-1:0]   r_retry;
  logic            r_devsel_seen;
  logic            r_tabort;
  logic            r_bme_lost;
  logic            r_mdata_d;
  logic            r_gap;
  logic [1:0]      r_status;
  logic [1:0]      w_end_status;
  logic            w_retry;
  logic [4:0]      w_len;
  logic            w_in_data;
  logic            w_addr_phase;
  logic [3:0]      w_cmd;
  logic            w_unused;

  assign w_unused = &{1'b0, M_SRC_EN, CSR[39:3], CSR[1:0], cmd_addr[1:0]};

  assign w_len = (cmd_len == 5'd0) ? 5'd1 :
                 (cmd_len > 5'(MAX_BURST)) ? 5'(MAX_BURST) : cmd_len;

`ifdef PCI_MST_READ_MULTIPLE_EN
  assign w_cmd = r_write ? 4'b0111 : ((r_rem > 5'd1) ? 4'b1100 : 4'b0110);
`else
  assign w_cmd = r_write ? 4'b0111 : 4'b0110;
`endif

  // State register
  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic and end-of-attempt classification
  always_comb begin
    w_next       = r_state;
    w_end_status = 2'b00;
    w_retry      = 1'b0;
    case (r_state)
      ST_IDLE:  if (cmd_valid && CSR[2]) w_next = ST_REQ;
      ST_REQ:   w_next = ST_ADDR;
      ST_ADDR:  if (!M_ADDR_N) w_next = ST_DATA;
      ST_DATA:  if ((r_mdata_d && !M_DATA) || TIME_OUT) w_next = ST_WAIT_END;
      ST_WAIT_END: begin
        w_next = ST_DONE;
        if (r_rem == 5'd0)       w_end_status = 2'b00;
        else if (!r_devsel_seen) w_end_status = 2'b10;
        else if (r_tabort)       w_end_status = 2'b11;
        else begin
          w_retry = 1'b1;
          if (r_retry >= RW'(RETRY_LIMIT) || r_bme_lost || !CSR[2])
            w_end_status = 2'b01;
          else
            w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_bme_lost || !CSR[2]) begin
          w_next       = ST_DONE;
          w_end_status = 2'b01;
        end else if (r_gap && I_IDLE) begin
          w_next = ST_REQ;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Command, progress and attempt-status registers
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_addr        <= '0;
      r_write       <= 1'b0;
      r_rem         <= '0;
      r_retry       <= '0;
      r_devsel_seen <= 1'b0;
      r_tabort      <= 1'b0;
      r_bme_lost    <= 1'b0;
      r_mdata_d     <= 1'b0;
      r_gap         <= 1'b0;
      r_status      <= 2'b00;
    end else begin
      r_mdata_d <= M_DATA;
      r_gap     <= (r_state == ST_GAP);
      if (r_state != ST_IDLE && !CSR[2]) r_bme_lost <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && CSR[2]) begin
            r_addr     <= cmd_addr[31:2];
            r_write    <= cmd_write;
            r_rem      <= w_len;
            r_retry    <= '0;
            r_bme_lost <= 1'b0;
            r_status   <= 2'b00;
          end
        end
        ST_REQ: begin
          r_devsel_seen <= 1'b0;
          r_tabort      <= 1'b0;
        end
        ST_ADDR: if (!DEVSELQ_N) r_devsel_seen <= 1'b1;
        ST_DATA: begin
          if (!DEVSELQ_N) r_devsel_seen <= 1'b1;
          // target abort: STOP with DEVSEL released after DEVSEL was claimed
          if (r_devsel_seen && !STOPQ_N && DEVSELQ_N) r_tabort <= 1'b1;
          if (M_DATA_VLD && r_rem != 5'd0) begin
            r_addr <= r_addr + 30'd1;
            r_rem  <= r_rem - 5'd1;
          end
        end
        ST_WAIT_END: if (w_retry) r_retry <= r_retry + RW'(1);
        default: ;
      endcase
      if (w_next == ST_DONE && r_state != ST_DONE) r_status <= w_end_status;
    end
  end

  assign w_in_data    = (r_state == ST_DATA);
  assign w_addr_phase = (r_state == ST_ADDR) && !M_ADDR_N;

  assign cmd_ready   = aresetn && (r_state == ST_IDLE) && CSR[2];
  assign REQUEST     = (r_state == ST_REQ);
  assign REQUESTHOLD = 1'b0;
  assign COMPLETE    = w_in_data && ((r_rem <= 5'd1) || (r_rem == 5'd2 && M_DATA_VLD));
  assign M_WRDN      = w_in_data && r_write;
  assign M_READY     = w_in_data && (!r_write || wr_valid);
  assign wr_ready    = w_in_data && r_write && M_DATA_VLD;
  assign rd_valid    = w_in_data && !r_write && M_DATA_VLD;
  assign rd_data     = (w_in_data && !r_write) ? ADIO_OUT : '0;
  assign M_CBE       = w_addr_phase ? w_cmd : (w_in_data ? 4'b0000 : 4'b1111);
  assign m_adio      = w_addr_phase ? {r_addr, 2'b00} :
                       ((w_in_data && r_write) ? wr_data : '0);
  assign done_valid  = (r_state == ST_DONE);
  assign done_status = r_status;

endmodule

// File: tb/tb_pci_master_ctrl.sv
// Directed bench for pci_master_ctrl (default build, RETRY_LIMIT = 2).
module tb_pci_master_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn, cmd_valid, cmd_ready, cmd_write, wr_valid, wr_ready;
  logic [31:0] cmd_addr, wr_data, rd_data, m_adio, ADIO_OUT;
  logic [4:0]  cmd_len;
  logic        rd_valid, done_valid;
  logic [1:0]  done_status;
  logic        REQUEST, REQUESTHOLD, COMPLETE, M_WRDN, M_READY;
  logic [3:0]  M_CBE;
  logic        M_DATA_VLD, M_SRC_EN, M_DATA, M_ADDR_N, TIME_OUT, STOPQ_N, DEVSELQ_N, I_IDLE;
  logic [39:0] CSR;

  int total = 0;
  int bad   = 0;
  int n_req = 0, n_wr = 0, n_rd = 0, n_done = 0;
  int req0, done0;

  always #5 aclk = ~aclk;

  pci_master_ctrl #(.MAX_BURST(16), .RETRY_LIMIT(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done_valid(done_valid), .done_status(done_status),
    .REQUEST(REQUEST), .REQUESTHOLD(REQUESTHOLD), .COMPLETE(COMPLETE), .M_WRDN(M_WRDN),
    .M_READY(M_READY), .M_CBE(M_CBE), .m_adio(m_adio),
    .M_DATA_VLD(M_DATA_VLD), .M_SRC_EN(M_SRC_EN), .M_DATA(M_DATA), .M_ADDR_N(M_ADDR_N),
    .TIME_OUT(TIME_OUT), .STOPQ_N(STOPQ_N), .DEVSELQ_N(DEVSELQ_N), .I_IDLE(I_IDLE),
    .ADIO_OUT(ADIO_OUT), .CSR(CSR)
  );

  // Event counters sampled mid-cycle
  always @(negedge aclk) begin
    if (REQUEST)    n_req++;
    if (wr_ready)   n_wr++;
    if (rd_valid)   n_rd++;
    if (done_valid) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_bus();
    M_ADDR_N   = 1'b1;
    M_DATA     = 1'b0;
    M_DATA_VLD = 1'b0;
    DEVSELQ_N  = 1'b1;
    STOPQ_N    = 1'b1;
    TIME_OUT   = 1'b0;
    wr_valid   = 1'b0;
  endtask

  // One attempt that the target disconnects without data; starts in REQ
  task automatic retry_attempt();
    #1 chkb("retry_req", REQUEST, 1'b1);
    cyc();
    M_ADDR_N = 1'b0;
    cyc();
    M_ADDR_N = 1'b1; M_DATA = 1'b1; DEVSELQ_N = 1'b0; STOPQ_N = 1'b0;
    cyc();
    M_DATA = 1'b0;
    cyc();
    idle_bus();
    cyc();
  endtask

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_len = '0;
    wr_data = '0; M_SRC_EN = 1'b0; ADIO_OUT = '0; CSR = '0; I_IDLE = 1'b1;
    idle_bus();
    repeat (3) cyc();
    #1;
    chk ("rst_cbe",     32'(M_CBE), 32'hF);
    chkb("rst_request", REQUEST, 1'b0);
    chkb("rst_mready",  M_READY, 1'b0);
    chkb("rst_complete",COMPLETE, 1'b0);
    chkb("rst_done",    done_valid, 1'b0);
    chk ("rst_adio",    m_adio, 32'h0);

    // Bus master disabled: command held but not accepted
    aresetn = 1'b1;
    cmd_valid = 1'b1; cmd_addr = 32'h1000_0041; cmd_write = 1'b1; cmd_len = 5'd4;
    repeat (3) begin
      cyc(); #1;
      chkb("bme_off_ready", cmd_ready, 1'b0);
    end
    chk("bme_off_noreq", n_req, 0);
    CSR[2] = 1'b1;
    #1 chkb("bme_on_ready", cmd_ready, 1'b1);

    // Write 4 words to 0x1000_0040, all accepted
    cyc(); cmd_valid = 1'b0;
    #1 chkb("wr_req", REQUEST, 1'b1);
    cyc();
    #1 chkb("wr_req_once", REQUEST, 1'b0);
    chk("wr_cbe_wait", 32'(M_CBE), 32'hF);
    M_ADDR_N = 1'b0;
    #1 chk("wr_addr", m_adio, 32'h1000_0040);
    chk("wr_cmd", 32'(M_CBE), 32'h7);
    cyc();
    M_ADDR_N = 1'b1; M_DATA = 1'b1; DEVSELQ_N = 1'b0; wr_valid = 1'b1; M_DATA_VLD = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_data = 32'hA000_0000 + 32'(k);
      #1;
      chkb("wr_ready", wr_ready, 1'b1);
      chk ("wr_adio", m_adio, 32'hA000_0000 + 32'(k));
      chkb("wr_complete", COMPLETE, k >= 2);
      chkb("wr_mready", M_READY, 1'b1);
      chkb("wr_wrdn", M_WRDN, 1'b1);
      chk ("wr_cbe_data", 32'(M_CBE), 32'h0);
      cyc();
    end
    idle_bus();
    cyc();
    #1 chkb("wr_wait_end", done_valid, 1'b0);
    cyc();
    #1 chkb("wr_done", done_valid, 1'b1);
    chk("wr_status", 32'(done_status), 32'h0);
    chk("wr_nreq", n_req, 1);
    chk("wr_npop", n_wr, 4);
    cyc();
    #1 chkb("wr_done_pulse", done_valid, 1'b0);
    chkb("wr_idle_ready", cmd_ready, 1'b1);

    // Read 8 words, disconnect after 3, resume at +12 with 5 remaining
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h2000_0100; cmd_len = 5'd8;
    cyc(); cmd_valid = 1'b0;
    #1 chkb("rd_req", REQUEST, 1'b1);
    cyc();
    M_ADDR_N = 1'b0;
    #1 chk("rd_addr", m_adio, 32'h2000_0100);
    chk("rd_cmd", 32'(M_CBE), 32'h6);
    cyc();
    M_ADDR_N = 1'b1; M_DATA = 1'b1; DEVSELQ_N = 1'b0; M_DATA_VLD = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ADIO_OUT = 32'hB000_0000 + 32'(k);
      #1;
      chkb("rd_valid", rd_valid, 1'b1);
      chk ("rd_data", rd_data, 32'hB000_0000 + 32'(k));
      chkb("rd_complete", COMPLETE, 1'b0);
      chkb("rd_wrdn", M_WRDN, 1'b0);
      chkb("rd_mready", M_READY, 1'b1);
      cyc();
    end
    M_DATA_VLD = 1'b0; M_DATA = 1'b0; STOPQ_N = 1'b0;
    #1 chkb("rd_disc_novalid", rd_valid, 1'b0);
    cyc();
    idle_bus(); I_IDLE = 1'b0;
    #1 chkb("rd_disc_nodone", done_valid, 1'b0);
    cyc();
    #1 chkb("rd_gap1", REQUEST, 1'b0);
    cyc();
    #1 chkb("rd_gap2", REQUEST, 1'b0);
    cyc();
    I_IDLE = 1'b1;
    #1 chkb("rd_gap_hold", REQUEST, 1'b0);
    cyc();
    #1 chkb("rd_req2", REQUEST, 1'b1);
    cyc();
    M_ADDR_N = 1'b0;
    #1 chk("rd_addr2", m_adio, 32'h2000_010C);
    cyc();
    M_ADDR_N = 1'b1; M_DATA = 1'b1; DEVSELQ_N = 1'b0; M_DATA_VLD = 1'b1;
    for (int k = 3; k < 8; k++) begin
      ADIO_OUT = 32'hB000_0000 + 32'(k);
      #1;
      chk ("rd_data2", rd_data, 32'hB000_0000 + 32'(k));
      chkb("rd_complete2", COMPLETE, k >= 6);
      cyc();
    end
    idle_bus();
    cyc();
    cyc();
    #1 chkb("rd_done", done_valid, 1'b1);
    chk("rd_status", 32'(done_status), 32'h0);
    chk("rd_nreq", n_req, 3);
    chk("rd_nvalid", n_rd, 8);
    cyc();

    // Master abort: no DEVSEL
    cmd_valid = 1'b1; cmd_addr = 32'h3000_0000; cmd_len = 5'd2;
    cyc(); cmd_valid = 1'b0;
    cyc();
    M_ADDR_N = 1'b0;
    cyc();
    M_ADDR_N = 1'b1; M_DATA = 1'b1;
    #1 chkb("ma_complete", COMPLETE, 1'b0);
    cyc();
    cyc();
    M_DATA = 1'b0;
    cyc();
    cyc();
    #1 chkb("ma_done", done_valid, 1'b1);
    chk("ma_status", 32'(done_status), 32'h2);
    chk("ma_nvalid", n_rd, 8);
    cyc();
    #1 chkb("ma_idle", cmd_ready, 1'b1);

    // Every attempt retried, RETRY_LIMIT = 2
    req0 = n_req;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0000; cmd_len = 5'd1;
    cyc(); cmd_valid = 1'b0;
    retry_attempt();
    cyc(); cyc();
    retry_attempt();
    cyc(); cyc();
    retry_attempt();
    #1 chkb("rt_done", done_valid, 1'b1);
    chk("rt_status", 32'(done_status), 32'h1);
    chk("rt_nreq", n_req - req0, 3);
    cyc();

    // Target abort: DEVSEL claimed then released with STOP
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5000_0000; cmd_len = 5'd4;
    cyc(); cmd_valid = 1'b0;
    cyc();
    M_ADDR_N = 1'b0;
    cyc();
    M_ADDR_N = 1'b1; M_DATA = 1'b1; DEVSELQ_N = 1'b0;
    cyc();
    DEVSELQ_N = 1'b1; STOPQ_N = 1'b0;
    cyc();
    M_DATA = 1'b0;
    cyc();
    idle_bus();
    cyc();
    #1 chkb("ta_done", done_valid, 1'b1);
    chk("ta_status", 32'(done_status), 32'h3);
    cyc();

    // Bus master enable drops mid-write: disconnect ends with 01, no retry
    req0 = n_req;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h6000_0000; cmd_len = 5'd2;
    cyc(); cmd_valid = 1'b0;
    cyc();
    M_ADDR_N = 1'b0;
    cyc();
    M_ADDR_N = 1'b1; M_DATA = 1'b1; DEVSELQ_N = 1'b0; wr_valid = 1'b1; M_DATA_VLD = 1'b1;
    wr_data = 32'hC0DE_0001; CSR[2] = 1'b0;
    #1 chkb("bd_pop", wr_ready, 1'b1);
    cyc();
    wr_valid = 1'b0; M_DATA_VLD = 1'b0; M_DATA = 1'b0; STOPQ_N = 1'b0;
    cyc();
    idle_bus();
    cyc();
    #1 chkb("bd_done", done_valid, 1'b1);
    chk("bd_status", 32'(done_status), 32'h1);
    chk("bd_nreq", n_req - req0, 1);
    CSR[2] = 1'b1;
    cyc();

    // Reset during DATA
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h7000_0000; cmd_len = 5'd4;
    cyc(); cmd_valid = 1'b0;
    cyc();
    M_ADDR_N = 1'b0;
    cyc();
    M_ADDR_N = 1'b1; M_DATA = 1'b1; DEVSELQ_N = 1'b0; M_DATA_VLD = 1'b1;
    #1 chkb("rs_mready_pre", M_READY, 1'b1);
    aresetn = 1'b0;
    done0 = n_done;
    cyc();
    idle_bus();
    #1;
    chk ("rs_cbe", 32'(M_CBE), 32'hF);
    chkb("rs_request", REQUEST, 1'b0);
    chkb("rs_mready", M_READY, 1'b0);
    chkb("rs_complete", COMPLETE, 1'b0);
    aresetn = 1'b1;
    repeat (4) cyc();
    chk("rs_nodone", n_done - done0, 0);
    chkb("rs_idle_ready", cmd_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
